sine_lut_loader: RTL and testbench

SINE_LUT_LOADER -- requirements
Module: sine_lut_loader

---
 rtl/sine_lut_loader.sv | 140 ++++++++++++++
 tb/tb_sine_lut_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sine_lut_loader.sv
// Byte-stream loader for a quarter-wave sine LUT: 12-bit samples arrive as hi/lo byte
// pairs and are followed by a 16-bit big-endian checksum of all accepted samples.
module sine_lut_loader #(
  parameter int _LUT_ADDR_WIDTH = 10,
  parameter int _SAMPLE_WIDTH   = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [7:0]                 i_byte,
  input  logic                       i_byte_valid,
  output logic                       o_byte_ready,
  output logic                       o_wr_en,
  output logic [_LUT_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [_SAMPLE_WIDTH-1:0]   o_wr_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error,
  output logic [15:0]                o_checksum
);

  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_CHK_HI, S_CHK_LO, S_DONE, S_ERR
  } state_t;

  localparam logic [_LUT_ADDR_WIDTH-1:0] LAST_IDX = '1;

  state_t                       state_q, state_d;
  logic [_LUT_ADDR_WIDTH-1:0]   index_q, index_d;
  logic [15:0]                  checksum_q, checksum_d;
  logic [_SAMPLE_WIDTH-1:0]     prev_q, prev_d;
  logic [3:0]                   hi_q, hi_d;
  logic [7:0]                   exp_hi_q, exp_hi_d;
  logic                         ready_q, ready_d;
  logic                         wr_en_q, wr_en_d;
  logic [_LUT_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [_SAMPLE_WIDTH-1:0]     wr_data_q, wr_data_d;

  logic                         xfer;
  logic [_SAMPLE_WIDTH-1:0]     sample;

  assign xfer   = i_byte_valid && ready_q;
  assign sample = _SAMPLE_WIDTH'({hi_q, i_byte});

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    checksum_d = checksum_q;
    prev_d     = prev_q;
    hi_d       = hi_q;
    exp_hi_d   = exp_hi_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    // A start pulse overrides any byte presented in the same cycle.
    if (i_start) begin
      state_d    = S_HI;
      index_d    = '0;
      checksum_d = '0;
      prev_d     = '0;
      hi_d       = '0;
    end else begin
      case (state_q)
        S_HI: if (xfer) begin
          if (i_byte[7:4] != 4'd0) begin
            state_d = S_ERR;
          end else begin
            hi_d    = i_byte[3:0];
            state_d = S_LO;
          end
        end
        S_LO: if (xfer) begin
          if (index_q != '0 && sample < prev_q) begin
            state_d = S_ERR;
          end else begin
            wr_en_d    = 1'b1;
            wr_addr_d  = index_q;
            wr_data_d  = sample;
            checksum_d = checksum_q + 16'(sample);
            prev_d     = sample;
            if (index_q == LAST_IDX) begin
              state_d = S_CHK_HI;
            end else begin
              index_d = index_q + 1'b1;
              state_d = S_HI;
            end
          end
        end
        S_CHK_HI: if (xfer) begin
          exp_hi_d = i_byte;
          state_d  = S_CHK_LO;
        end
        S_CHK_LO: if (xfer) begin
          state_d = ({exp_hi_q, i_byte} == checksum_q) ? S_DONE : S_ERR;
        end
        default: ;
      endcase
    end

    ready_d = (state_d == S_HI) || (state_d == S_LO) ||
              (state_d == S_CHK_HI) || (state_d == S_CHK_LO);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      checksum_q <= '0;
      prev_q     <= '0;
      hi_q       <= '0;
      exp_hi_q   <= '0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      checksum_q <= checksum_d;
      prev_q     <= prev_d;
      hi_q       <= hi_d;
      exp_hi_q   <= exp_hi_d;
      ready_q    <= ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign o_byte_ready = ready_q;
  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_busy       = ready_q;
  assign o_done       = (state_q == S_DONE);
  assign o_error      = (state_q == S_ERR);
  assign o_checksum   = checksum_q;

endmodule

// File: tb/tb_sine_lut_loader.sv
// Self-checking bench for sine_lut_loader with a 4-entry LUT: expected LUT writes are
// queued by a small host model and compared as the DUT strobes o_wr_en.
module tb_sine_lut_loader;

  localparam int AW = 2;
  localparam int NS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    din;
  logic          din_valid;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [15:0]   checksum;

  int n_vec    = 0;
  int n_miscmp = 0;

  logic [15:0] exp_q[$];

  // host model of the load in progress
  int          m_idx;
  logic [11:0] m_prev;
  logic [15:0] m_sum;

  always #5 clk = ~clk;

  sine_lut_loader #(._LUT_ADDR_WIDTH(AW), ._SAMPLE_WIDTH(12)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_byte       (din),
    .i_byte_valid (din_valid),
    .o_byte_ready (byte_ready),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_checksum   (checksum)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check_value("wr_unexpected", 32'(wr_en), 32'd0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        $display("wr addr=%0d data=%03h (expect addr=%0d data=%03h)", wr_addr, wr_data, e[13:12], e[11:0]);
        check_value("wr_addr", 32'(wr_addr), 32'(e[13:12]));
        check_value("wr_data", 32'(wr_data), 32'(e[11:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_idx  = 0;
    m_prev = '0;
    m_sum  = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    din       = b;
    din_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      n++;
      if (n > 50) begin
        check_value("ready_timeout", 32'(byte_ready), 32'd1);
        din_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic send_sample(input logic [11:0] s, input bit gap);
    send_byte({4'h0, s[11:8]}, gap);
    if (!(m_idx > 0 && s < m_prev) && m_idx < NS) begin
      exp_q.push_back({2'b00, 2'(m_idx), s});
      m_sum  = m_sum + 16'(s);
      m_prev = s;
      m_idx++;
    end
    send_byte(s[7:0], gap);
  endtask

  task automatic send_stream(input logic [11:0] s0, input logic [11:0] s1,
                             input logic [11:0] s2, input logic [11:0] s3,
                             input logic [15:0] cks, input bit gap);
    send_sample(s0, gap);
    send_sample(s1, gap);
    send_sample(s2, gap);
    send_sample(s3, gap);
    send_byte(cks[15:8], gap);
    send_byte(cks[7:0], gap);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_value({pfx, "_ready"},    32'(byte_ready), 32'd0);
    check_value({pfx, "_wr_en"},    32'(wr_en),      32'd0);
    check_value({pfx, "_wr_addr"},  32'(wr_addr),    32'd0);
    check_value({pfx, "_wr_data"},  32'(wr_data),    32'd0);
    check_value({pfx, "_busy"},     32'(busy),       32'd0);
    check_value({pfx, "_done"},     32'(done),       32'd0);
    check_value({pfx, "_error"},    32'(error),      32'd0);
    check_value({pfx, "_checksum"}, 32'(checksum),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_vec %0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; din = 8'h00; din_valid = 1'b0;
    m_idx = 0; m_prev = '0; m_sum = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // good load
    pulse_start();
    check_value("start_busy", 32'(busy), 32'd1);
    send_stream(12'h000, 12'h100, 12'h200, 12'h3FF, 16'h06FF, 1'b0);
    check_value("good_checksum", 32'(checksum), 32'h06FF);
    check_value("good_model_sum", 32'(checksum), 32'(m_sum));
    check_value("good_done", 32'(done), 32'd1);
    check_value("good_error", 32'(error), 32'd0);
    check_value("good_busy", 32'(busy), 32'd0);
    check_value("good_ready", 32'(byte_ready), 32'd0);
    repeat (2) tick();
    check_value("good_done_sticky", 32'(done), 32'd1);

    // bad checksum
    pulse_start();
    check_value("restart_done_clr", 32'(done), 32'd0);
    send_stream(12'h000, 12'h100, 12'h200, 12'h3FF, 16'h06FE, 1'b0);
    check_value("badcks_error", 32'(error), 32'd1);
    check_value("badcks_done", 32'(done), 32'd0);
    check_value("badcks_checksum", 32'(checksum), 32'h06FF);

    // bad hi byte
    pulse_start();
    check_value("badhi_cks_clr", 32'(checksum), 32'd0);
    check_value("badhi_err_clr", 32'(error), 32'd0);
    send_byte(8'h10, 1'b0);
    check_value("badhi_error", 32'(error), 32'd1);
    check_value("badhi_ready", 32'(byte_ready), 32'd0);
    din = 8'h00; din_valid = 1'b1;
    repeat (4) tick();
    din_valid = 1'b0;
    check_value("badhi_error_sticky", 32'(error), 32'd1);
    check_value("badhi_busy", 32'(busy), 32'd0);

    // non-monotonic samples
    pulse_start();
    send_sample(12'h100, 1'b0);
    send_sample(12'h0FF, 1'b0);
    check_value("nonmono_error", 32'(error), 32'd1);
    check_value("nonmono_checksum", 32'(checksum), 32'h0100);
    repeat (2) tick();

    // valid toggled, restart while the low byte of sample 2 is presented
    pulse_start();
    send_sample(12'h010, 1'b1);
    send_sample(12'h020, 1'b1);
    send_byte(8'h00, 1'b1);
    din = 8'h30; din_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; din_valid = 1'b0;
    m_idx = 0; m_prev = '0; m_sum = '0;
    check_value("restart_busy", 32'(busy), 32'd1);
    check_value("restart_checksum", 32'(checksum), 32'd0);
    check_value("restart_ready", 32'(byte_ready), 32'd1);
    send_stream(12'h005, 12'h006, 12'h007, 12'h008, 16'h001A, 1'b1);
    check_value("toggle_done", 32'(done), 32'd1);
    check_value("toggle_checksum", 32'(checksum), 32'(m_sum));

    // reset in the middle of a load
    pulse_start();
    send_sample(12'h050, 1'b0);
    send_byte(8'h00, 1'b0);
    rst_n = 1'b0; din = 8'h60; din_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    repeat (6) begin
      din = din + 8'h01;
      tick();
    end
    din_valid = 1'b0;
    check_value("midrst_ready_after", 32'(byte_ready), 32'd0);

    repeat (3) tick();
    check_value("pending_wr", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
